// File: rtl/wb_unit.sv
`default_nettype none
// ============================================================================
// Module      : wb_unit
// Description : Writeback unit of the npc core. It accepts completed results
//               from the LSU and the ALU over valid/ready handshakes, buffers
//               them in an in-order FIFO and retires at most one result per
//               cycle onto the GPR write port. A per-register pending-write
//               scoreboard lets decode detect RAW hazards against writes that
//               have not yet retired.
//
// Ports       : clk, rst_n                 clock, async active-low reset
//               i_lsu_valid/o_lsu_ready    LSU result handshake (+ rd, data)
//               i_alu_valid/o_alu_ready    ALU result handshake (+ rd, data)
//               i_issue_en/i_issue_rd      destination issued this cycle
//               o_issue_ready              scoreboard can take i_issue_rd
//               i_rs1_addr/i_rs2_addr      hazard query addresses
//               o_rs1_busy/o_rs2_busy      pending write exists
//               o_rf_wen/waddr/wdata       GPR write port
//               o_count                    FIFO occupancy
//
// Config      : WB_BYPASS_EN - when defined, a single result arriving while
//               the FIFO is empty is written to the GPR in the same cycle
//               instead of being pushed.
//
// Revision    : 1.0 - initial release
// ============================================================================
module wb_unit #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       i_lsu_valid,
    output logic                       o_lsu_ready,
    input  logic [ADDR_WIDTH-1:0]      i_lsu_rd,
    input  logic [DATA_WIDTH-1:0]      i_lsu_data,

    input  logic                       i_alu_valid,
    output logic                       o_alu_ready,
    input  logic [ADDR_WIDTH-1:0]      i_alu_rd,
    input  logic [DATA_WIDTH-1:0]      i_alu_data,

    input  logic                       i_issue_en,
    input  logic [ADDR_WIDTH-1:0]      i_issue_rd,
    output logic                       o_issue_ready,

    input  logic [ADDR_WIDTH-1:0]      i_rs1_addr,
    input  logic [ADDR_WIDTH-1:0]      i_rs2_addr,
    output logic                       o_rs1_busy,
    output logic                       o_rs2_busy,

    output logic                       o_rf_wen,
    output logic [ADDR_WIDTH-1:0]      o_rf_waddr,
    output logic [DATA_WIDTH-1:0]      o_rf_wdata,

    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_NREG  = 1 << ADDR_WIDTH;
    localparam int c_ENT_W = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    // FIFO storage and bookkeeping
    logic [c_ENT_W-1:0]    r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wptr;
    logic [c_PTR_W-1:0]    r_rptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_active;

    // Pending-write counters; entry 0 is never written so x0 never looks busy
    logic [1:0]            r_pend [c_NREG];

    logic [c_CNT_W-1:0]    w_free;
    logic                  w_lsu_fire;
    logic                  w_alu_fire;
    logic                  w_byp_lsu;
    logic                  w_byp_alu;
    logic                  w_push_lsu;
    logic                  w_push_alu;
    logic                  w_pop;
    logic [1:0]            w_npush;
    logic [c_PTR_W-1:0]    w_wptr_p1;
    logic                  w_issue_ok;

    // ------------------------------------------------------------------
    // Handshakes. Free space ignores a same-cycle pop, so ready depends only
    // on registered occupancy (plus the LSU valid for ALU arbitration).
    // r_active keeps both readies low during reset and until the first
    // edge after release.
    // ------------------------------------------------------------------
    assign w_free      = c_DEPTH - r_count;
    assign o_lsu_ready = r_active && (w_free != '0);
    assign o_alu_ready = r_active &&
                         ((w_free >= c_CNT_W'(2)) || ((w_free != '0) && !i_lsu_valid));

    assign w_lsu_fire  = i_lsu_valid && o_lsu_ready;
    assign w_alu_fire  = i_alu_valid && o_alu_ready;

`ifdef WB_BYPASS_EN
    // Only a lone result into an empty FIFO may skip the queue; keeping both
    // in the FIFO when both fire preserves LSU-before-ALU ordering.
    assign w_byp_lsu = (r_count == '0) && w_lsu_fire && !w_alu_fire && (i_lsu_rd != '0);
    assign w_byp_alu = (r_count == '0) && w_alu_fire && !w_lsu_fire && (i_alu_rd != '0);
`else
    assign w_byp_lsu = 1'b0;
    assign w_byp_alu = 1'b0;
`endif

    // rd = 0 results complete their handshake but are dropped here
    assign w_push_lsu = w_lsu_fire && (i_lsu_rd != '0) && !w_byp_lsu;
    assign w_push_alu = w_alu_fire && (i_alu_rd != '0) && !w_byp_alu;
    assign w_npush    = {1'b0, w_push_lsu} + {1'b0, w_push_alu};
    assign w_pop      = (r_count != '0);
    assign w_wptr_p1  = r_wptr + 1'b1;

    // ------------------------------------------------------------------
    // GPR write port: FIFO head when non-empty, otherwise an optional bypass.
    // Address/data are forced to zero when idle so reset shows a clean port.
    // ------------------------------------------------------------------
    always_comb begin
        o_rf_wen   = 1'b0;
        o_rf_waddr = '0;
        o_rf_wdata = '0;
        if (w_pop) begin
            o_rf_wen                 = 1'b1;
            {o_rf_waddr, o_rf_wdata} = r_mem[r_rptr];
        end else if (w_byp_lsu) begin
            o_rf_wen   = 1'b1;
            o_rf_waddr = i_lsu_rd;
            o_rf_wdata = i_lsu_data;
        end else if (w_byp_alu) begin
            o_rf_wen   = 1'b1;
            o_rf_waddr = i_alu_rd;
            o_rf_wdata = i_alu_data;
        end
    end

    // Storage needs no reset: occupancy gates every read of it.
    // On a double push the LSU entry takes the first slot.
    always_ff @(posedge clk) begin
        if (w_push_lsu) begin
            r_mem[r_wptr] <= {i_lsu_rd, i_lsu_data};
        end
        if (w_push_alu) begin
            r_mem[w_push_lsu ? w_wptr_p1 : r_wptr] <= {i_alu_rd, i_alu_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
            r_wptr   <= r_wptr + c_PTR_W'(w_npush);
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count  <= r_count + c_CNT_W'(w_npush) - c_CNT_W'(w_pop);
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    assign o_issue_ready = (r_pend[i_issue_rd] != 2'd3);
    assign w_issue_ok    = i_issue_en && o_issue_ready && (i_issue_rd != '0);
    assign o_rs1_busy    = (r_pend[i_rs1_addr] != 2'd0);
    assign o_rs2_busy    = (r_pend[i_rs2_addr] != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_NREG; i++) begin
                r_pend[i] <= 2'd0;
            end
        end else begin
            for (int i = 1; i < c_NREG; i++) begin
                // Simultaneous increment and decrement cancel. A decrement
                // of an idle counter is a producer error and is absorbed.
                if (w_issue_ok && (i_issue_rd == ADDR_WIDTH'(i)) &&
                    !(o_rf_wen && (o_rf_waddr == ADDR_WIDTH'(i)))) begin
                    r_pend[i] <= r_pend[i] + 2'd1;
                end else if (o_rf_wen && (o_rf_waddr == ADDR_WIDTH'(i)) &&
                             !(w_issue_ok && (i_issue_rd == ADDR_WIDTH'(i))) &&
                             (r_pend[i] != 2'd0)) begin
                    r_pend[i] <= r_pend[i] - 2'd1;
                end
            end
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire
